msg_queue: RTL

- Downstream stage of the message parser: captures every parsed-message pulse (msg_valid with msg_length/msg_data/msg_error) into a DEPTH-entry FIFO.
- Presents queued messages to a consumer over a valid/ready handshake.
- The parser output has no backpressure, so this block absorbs bursts and counts any messages it is forced to drop.

---
 rtl/msg_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/msg_queue.sv
// Message FIFO behind the parser: holds bursts of parsed messages, hands them out on a valid/ready port, counts drops.
// Optional MSG_QUEUE_DROP_ERR_EN: errored messages are never stored; they are counted on err_drop_cnt.
module msg_queue #(
   parameter int MAX_MSG_BYTES = 32,
   parameter int DEPTH         = 4,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         msg_valid,
   input  logic [15:0]                  msg_length,
   input  logic [8*MAX_MSG_BYTES-1:0]   msg_data,
   input  logic                         msg_error,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [15:0]                  out_length,
   output logic [8*MAX_MSG_BYTES-1:0]   out_data,
   output logic                         out_error,
   output logic [$clog2(DEPTH):0]       q_count,
   output logic                         q_full,
   output logic                         q_empty,
   output logic [CNT_WIDTH-1:0]         ovf_drop_cnt,
`ifdef MSG_QUEUE_DROP_ERR_EN
   output logic [CNT_WIDTH-1:0]         err_drop_cnt,
`endif
   output logic                         ovf_pulse
);

   localparam int PW = $clog2(DEPTH);
   localparam int DW = 8*MAX_MSG_BYTES;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [15:0]          r_len  [DEPTH];
   logic [DW-1:0]        r_data [DEPTH];
   logic [PW-1:0]        r_wr_ptr;
   logic [PW-1:0]        r_rd_ptr;
   logic [PW:0]          r_count;
   logic [CNT_WIDTH-1:0] r_ovf_cnt;
   logic                 r_ovf_pulse;

   logic w_accept;
   logic w_push;
   logic w_pop;
   logic w_ovf;
   logic w_full;
   logic w_empty;

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_pop   = ~w_empty & out_ready;

`ifdef MSG_QUEUE_DROP_ERR_EN
   logic                 w_err_drop;
   logic [CNT_WIDTH-1:0] r_err_cnt;

   // Filtering wins over overflow, so an errored message never reaches the full check.
   assign w_err_drop = msg_valid & msg_error;
   assign w_accept   = msg_valid & ~msg_error;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (w_err_drop && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign err_drop_cnt = r_err_cnt;
   assign out_error    = 1'b0;
`else
   logic r_err [DEPTH];

   assign w_accept  = msg_valid;
   assign out_error = w_empty ? 1'b0 : r_err[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_err[r_wr_ptr] <= msg_error;
      end
   end
`endif

   assign w_push = w_accept & (~w_full | w_pop);
   assign w_ovf  = w_accept & w_full & ~w_pop;

   // Payload storage is not reset; the outputs are masked while empty instead.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_len[r_wr_ptr]  <= msg_length;
         r_data[r_wr_ptr] <= msg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf_cnt   <= '0;
         r_ovf_pulse <= 1'b0;
      end else begin
         r_ovf_pulse <= w_ovf;
         if (w_ovf && (r_ovf_cnt != '1)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
         end
      end
   end

   assign out_valid    = ~w_empty;
   assign out_length   = w_empty ? '0 : r_len[r_rd_ptr];
   assign out_data     = w_empty ? '0 : r_data[r_rd_ptr];
   assign q_count      = r_count;
   assign q_full       = w_full;
   assign q_empty      = w_empty;
   assign ovf_drop_cnt = r_ovf_cnt;
   assign ovf_pulse    = r_ovf_pulse;

endmodule
